// File: rtl/decode_stage.sv
// decode_stage: MIPS ID stage -- field split, control decode, load-use hazard detection, ID/EX register.
//
// Ports:
//   clk, reset                     clock and synchronous active-high reset
//   id_instr, id_pc_plus4          instruction and PC+4 from the IF/ID latch
//   id_valid                       IF/ID holds a real instruction
//   flush                          squash the instruction in ID (branch taken in EX)
//   rf_read_addr_a/b               rs/rt to the register file (combinational)
//   rf_data_a/b                    register file read data
//   wb_reg_write/addr/data         write-back port, used only for the optional bypass
//   stall                          hold PC and IF/ID this cycle (combinational)
//   ex_*                           registered ID/EX fields and control
//
// Build option: define WB_BYPASS_EN to forward same-cycle write-back data into the operands.
module decode_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       id_instr,
    input  logic [31:0]       id_pc_plus4,
    input  logic              id_valid,
    input  logic              flush,
    output logic [ADDR_W-1:0] rf_read_addr_a,
    output logic [ADDR_W-1:0] rf_read_addr_b,
    input  logic [DATA_W-1:0] rf_data_a,
    input  logic [DATA_W-1:0] rf_data_b,
    input  logic              wb_reg_write,
    input  logic [ADDR_W-1:0] wb_write_addr,
    input  logic [DATA_W-1:0] wb_write_data,
    output logic              stall,
    output logic              ex_valid,
    output logic [31:0]       ex_pc_plus4,
    output logic [DATA_W-1:0] ex_data_a,
    output logic [DATA_W-1:0] ex_data_b,
    output logic [31:0]       ex_imm,
    output logic [ADDR_W-1:0] ex_rs,
    output logic [ADDR_W-1:0] ex_rt,
    output logic [ADDR_W-1:0] ex_write_reg,
    output logic [5:0]        ex_funct,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_alu_src,
    output logic              ex_branch,
    output logic [1:0]        ex_alu_op,
    output logic              ex_illegal
);

    typedef struct packed {
        logic              valid;
        logic [31:0]       pc_plus4;
        logic [DATA_W-1:0] data_a;
        logic [DATA_W-1:0] data_b;
        logic [31:0]       imm;
        logic [ADDR_W-1:0] rs;
        logic [ADDR_W-1:0] rt;
        logic [ADDR_W-1:0] write_reg;
        logic [5:0]        funct;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              alu_src;
        logic              branch;
        logic [1:0]        alu_op;
        logic              illegal;
    } idex_t;

    idex_t idex_q, idex_d;

    logic [5:0]        opcode;
    logic [ADDR_W-1:0] rs, rt, rd, write_reg;
    logic              reg_dst, reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, illegal;
    logic              uses_rt, hazard;
    logic [1:0]        alu_op;
    logic [DATA_W-1:0] op_a, op_b;

    assign opcode = id_instr[31:26];
    assign rs     = ADDR_W'(id_instr[25:21]);
    assign rt     = ADDR_W'(id_instr[20:16]);
    assign rd     = ADDR_W'(id_instr[15:11]);

    assign rf_read_addr_a = rs;
    assign rf_read_addr_b = rt;

    always_comb begin
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        branch     = 1'b0;
        alu_op     = 2'b00;
        illegal    = 1'b0;
        case (opcode)
            6'h00: begin reg_dst = 1'b1; reg_write = 1'b1; alu_op = 2'b10; end
            6'h23: begin alu_src = 1'b1; mem_read = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1; end
            6'h2B: begin alu_src = 1'b1; mem_write = 1'b1; end
            6'h04: begin branch = 1'b1; alu_op = 2'b01; end
            6'h08: begin alu_src = 1'b1; reg_write = 1'b1; end
            default: illegal = 1'b1;
        endcase
    end

    assign write_reg = reg_dst ? rd : rt;
    assign uses_rt   = (opcode == 6'h00) || (opcode == 6'h2B) || (opcode == 6'h04);

    // Only a load still sitting in EX can have data not yet forwardable; $0 never conflicts.
    assign hazard = idex_q.valid && idex_q.mem_read && (idex_q.write_reg != '0) && id_valid &&
                    ((idex_q.write_reg == rs) || (uses_rt && (idex_q.write_reg == rt)));
    assign stall  = hazard && !flush;

`ifdef WB_BYPASS_EN
    assign op_a = (wb_reg_write && wb_write_addr != '0 && wb_write_addr == rs) ? wb_write_data : rf_data_a;
    assign op_b = (wb_reg_write && wb_write_addr != '0 && wb_write_addr == rt) ? wb_write_data : rf_data_b;
`else
    // The register file is write-first, so the write-back port is not needed here.
    logic              unused_wb;
    assign unused_wb = ^{wb_reg_write, wb_write_addr, wb_write_data};
    assign op_a = rf_data_a;
    assign op_b = rf_data_b;
`endif

    // Bubbles are fully zeroed so EX never sees stale data from a squashed slot.
    always_comb begin
        idex_d = '0;
        if (!(flush || hazard || !id_valid)) begin
            idex_d.valid      = 1'b1;
            idex_d.pc_plus4   = id_pc_plus4;
            idex_d.data_a     = op_a;
            idex_d.data_b     = op_b;
            idex_d.imm        = {{16{id_instr[15]}}, id_instr[15:0]};
            idex_d.rs         = rs;
            idex_d.rt         = rt;
            idex_d.write_reg  = write_reg;
            idex_d.funct      = id_instr[5:0];
            idex_d.reg_write  = reg_write && (write_reg != '0);
            idex_d.mem_read   = mem_read;
            idex_d.mem_write  = mem_write;
            idex_d.mem_to_reg = mem_to_reg;
            idex_d.alu_src    = alu_src;
            idex_d.branch     = branch;
            idex_d.alu_op     = alu_op;
            idex_d.illegal    = illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) idex_q <= '0;
        else       idex_q <= idex_d;
    end

    assign ex_valid      = idex_q.valid;
    assign ex_pc_plus4   = idex_q.pc_plus4;
    assign ex_data_a     = idex_q.data_a;
    assign ex_data_b     = idex_q.data_b;
    assign ex_imm        = idex_q.imm;
    assign ex_rs         = idex_q.rs;
    assign ex_rt         = idex_q.rt;
    assign ex_write_reg  = idex_q.write_reg;
    assign ex_funct      = idex_q.funct;
    assign ex_reg_write  = idex_q.reg_write;
    assign ex_mem_read   = idex_q.mem_read;
    assign ex_mem_write  = idex_q.mem_write;
    assign ex_mem_to_reg = idex_q.mem_to_reg;
    assign ex_alu_src    = idex_q.alu_src;
    assign ex_branch     = idex_q.branch;
    assign ex_alu_op     = idex_q.alu_op;
    assign ex_illegal    = idex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: randomized and directed checks of decode_stage against a behavioural ID/EX model.
module tb_decode_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, a, b, imm;
        logic [4:0]  rs, rt, wr;
        logic [5:0]  funct;
        logic        rw, mr, mw, m2r, asrc, br;
        logic [1:0]  aluop;
        logic        ill;
    } ex_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] id_instr = '0, id_pc_plus4 = '0;
    logic        id_valid = 1'b0, flush = 1'b0;
    logic [4:0]  rf_read_addr_a, rf_read_addr_b;
    logic [31:0] rf_data_a = '0, rf_data_b = '0;
    logic        wb_reg_write = 1'b0;
    logic [4:0]  wb_write_addr = '0;
    logic [31:0] wb_write_data = '0;
    logic        stall;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch, ex_illegal;
    logic [31:0] ex_pc_plus4, ex_data_a, ex_data_b, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_write_reg;
    logic [5:0]  ex_funct;
    logic [1:0]  ex_alu_op;

    int   vectors = 0;
    int   errors = 0;
    ex_t  m;
    ex_t  got;
    logic last_stall;

    always #5 clk = ~clk;

    decode_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
        .id_valid(id_valid), .flush(flush),
        .rf_read_addr_a(rf_read_addr_a), .rf_read_addr_b(rf_read_addr_b),
        .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
        .wb_reg_write(wb_reg_write), .wb_write_addr(wb_write_addr), .wb_write_data(wb_write_data),
        .stall(stall), .ex_valid(ex_valid), .ex_pc_plus4(ex_pc_plus4),
        .ex_data_a(ex_data_a), .ex_data_b(ex_data_b), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_write_reg(ex_write_reg), .ex_funct(ex_funct),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
        .ex_alu_op(ex_alu_op), .ex_illegal(ex_illegal)
    );

    assign got = {ex_valid, ex_pc_plus4, ex_data_a, ex_data_b, ex_imm, ex_rs, ex_rt, ex_write_reg,
                  ex_funct, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src,
                  ex_branch, ex_alu_op, ex_illegal};

    function automatic logic [31:0] operand(logic [4:0] r, logic [31:0] rf);
`ifdef WB_BYPASS_EN
        if (wb_reg_write && wb_write_addr != 0 && wb_write_addr == r) return wb_write_data;
`endif
        return rf;
    endfunction

    // What a valid instruction should look like once it reaches EX.
    function automatic ex_t decode(logic [31:0] i, logic [31:0] pc);
        ex_t e = '0;
        e.valid = 1'b1;
        e.pc    = pc;
        e.rs    = i[25:21];
        e.rt    = i[20:16];
        e.funct = i[5:0];
        e.imm   = 32'($signed(i[15:0]));
        e.a     = operand(e.rs, rf_data_a);
        e.b     = operand(e.rt, rf_data_b);
        e.wr    = e.rt;
        case (i[31:26])
            6'h00: begin e.wr = i[15:11]; e.rw = 1; e.aluop = 2; end
            6'h23: begin e.asrc = 1; e.mr = 1; e.m2r = 1; e.rw = 1; end
            6'h2B: begin e.asrc = 1; e.mw = 1; end
            6'h04: begin e.br = 1; e.aluop = 1; end
            6'h08: begin e.asrc = 1; e.rw = 1; end
            default: e.ill = 1;
        endcase
        if (e.wr == 0) e.rw = 0;
        return e;
    endfunction

    function automatic logic model_hazard(logic [31:0] i, logic v);
        logic [5:0] op = i[31:26];
        logic ur = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
        return m.valid && m.mr && m.wr != 0 && v && (m.wr == i[25:21] || (ur && m.wr == i[20:16]));
    endfunction

    task automatic chk(input string name, input logic [31:0] g, input logic [31:0] e);
        vectors++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, g, e);
        end
    endtask

    task automatic step(input logic rst, input logic [31:0] instr, input logic [31:0] pc,
                        input logic v, input logic f, input logic [31:0] da, input logic [31:0] db,
                        input logic wbw, input logic [4:0] wba, input logic [31:0] wbd);
        logic hz, es;
        ex_t  nxt;
        @(negedge clk);
        reset = rst; id_instr = instr; id_pc_plus4 = pc; id_valid = v; flush = f;
        rf_data_a = da; rf_data_b = db; wb_reg_write = wbw; wb_write_addr = wba; wb_write_data = wbd;
        #1;
        hz = model_hazard(instr, v);
        es = hz && !f;
        vectors++;
        if ({rf_read_addr_a, rf_read_addr_b, stall} !== {instr[25:21], instr[20:16], es}) begin
            errors++;
            $display("FAIL comb: got addr_a=%0d addr_b=%0d stall=%b expected %0d %0d %b",
                     rf_read_addr_a, rf_read_addr_b, stall, instr[25:21], instr[20:16], es);
        end
        last_stall = es;
        nxt = (rst || f || hz || !v) ? '0 : decode(instr, pc);
        @(posedge clk);
        #1;
        m = nxt;
        vectors++;
        if (got !== m) begin
            errors++;
            $display("FAIL idex: got %h expected %h", got, m);
        end
    endtask

    localparam logic [31:0] ADD = 32'h0022_1820;
    localparam logic [31:0] LW  = 32'h8C22_FFFC;
    localparam logic [5:0]  OPS [5] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08};

    initial begin
        logic [31:0] instr, pc;
        logic        v, held;
        m = '0;
        last_stall = 1'b0;

        step(1, ADD, 32'h100, 1, 0, 5, 7, 0, 0, 0);
        step(1, ADD, 32'h100, 1, 0, 5, 7, 0, 0, 0);
        chk("reset_clears", 32'(got), 32'h0);

        step(0, ADD, 32'h100, 1, 0, 5, 7, 0, 0, 0);
        chk("add_valid", 32'(ex_valid), 1);
        chk("add_data_a", ex_data_a, 5);
        chk("add_data_b", ex_data_b, 7);
        chk("add_wr", 32'(ex_write_reg), 3);
        chk("add_ctl", {29'h0, ex_reg_write, ex_alu_op}, 32'b110);

        step(0, LW, 32'h104, 1, 0, 1, 2, 0, 0, 0);
        chk("lw_imm", ex_imm, 32'hFFFF_FFFC);
        chk("lw_mem_read", 32'(ex_mem_read), 1);
        step(0, ADD, 32'h108, 1, 0, 1, 2, 0, 0, 0);
        chk("lu_stall", 32'(last_stall), 1);
        chk("lu_bubble", 32'(ex_valid), 0);
        step(0, ADD, 32'h108, 1, 0, 1, 2, 0, 0, 0);
        chk("lu_release", 32'(last_stall), 0);
        chk("lu_issue", {ex_valid, ex_funct, ex_pc_plus4[7:0]}, {1'b1, 6'h20, 8'h08});

        step(0, LW, 32'h10C, 1, 0, 1, 2, 0, 0, 0);
        step(0, ADD, 32'h110, 1, 1, 1, 2, 0, 0, 0);
        chk("flush_stall", 32'(last_stall), 0);
        chk("flush_bubble", 32'(ex_valid), 0);
        step(0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        chk("flush_no_dup", 32'(ex_valid), 0);

        step(0, ADD, 32'h114, 1, 0, 0, 0, 1, 1, 32'hDEAD_BEEF);
`ifdef WB_BYPASS_EN
        chk("bypass_hit", ex_data_a, 32'hDEAD_BEEF);
`else
        chk("bypass_off", ex_data_a, 0);
`endif
        step(0, ADD, 32'h118, 1, 0, 0, 0, 1, 0, 32'hDEAD_BEEF);
        chk("bypass_zero", ex_data_a, 0);

        step(0, 32'hFC22_1820, 32'h11C, 1, 0, 0, 0, 0, 0, 0);
        chk("illegal", {ex_valid, ex_illegal, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                        ex_alu_src, ex_branch, ex_alu_op}, {2'b11, 8'h0});
        step(0, 32'h2020_0001, 32'h120, 1, 0, 0, 0, 0, 0, 0);
        chk("addi_r0", {ex_valid, ex_alu_src, ex_reg_write}, 3'b110);
        step(0, 32'h8C22_FFFC, 32'h124, 0, 0, 3, 4, 0, 0, 0);
        chk("invalid", {ex_valid, ex_mem_read, ex_reg_write, last_stall}, 4'b0);

        held = 1'b0;
        instr = '0; pc = '0; v = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (!held) begin
                int sel = $urandom_range(0, 5);
                instr = $urandom;
                instr[31:26] = (sel == 5) ? 6'($urandom) : OPS[sel];
                instr[25:21] = 5'($urandom_range(0, 3));
                instr[20:16] = 5'($urandom_range(0, 3));
                instr[15:11] = 5'($urandom_range(0, 3));
                v  = $urandom_range(0, 9) != 0;
                pc = $urandom;
            end
            step($urandom_range(0, 99) == 0, instr, pc, v, $urandom_range(0, 9) == 0,
                 $urandom, $urandom, 1'($urandom), 5'($urandom_range(0, 3)), $urandom);
            held = last_stall;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage of the 5-stage MIPS pipeline; sits between the IF/ID latch and the EX stage.
- Splits the instruction into fields and drives the register-file read addresses. Captures the returned operands, with an optional write-back bypass.
- Generates control bits, detects load-use hazards (stall plus bubble) and holds the ID/EX pipeline register.

Parameters:
DATA_W, 32, register/operand width; the instruction word is fixed at 32 bits
ADDR_W, 5, register address width

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
id_instr  input  32  instruction from the IF/ID latch
id_pc_plus4  input  32  PC+4 from the IF/ID latch
id_valid  input  1  IF/ID holds a real instruction
flush  input  1  branch taken in EX; squash the instruction in ID
rf_read_addr_a  output  ADDR_W  rs, to the register file read port A (combinational)
rf_read_addr_b  output  ADDR_W  rt, to the register file read port B (combinational)
rf_data_a  input  DATA_W  register file port A data
rf_data_b  input  DATA_W  register file port B data
wb_reg_write  input  1  write-back stage writes this cycle
wb_write_addr  input  ADDR_W  write-back destination
wb_write_data  input  DATA_W  write-back data
stall  output  1  hold PC and IF/ID this cycle (combinational)
ex_valid, ex_pc_plus4[32], ex_data_a[DATA_W], ex_data_b[DATA_W], ex_imm[32]  output  registered ID/EX fields
ex_rs[ADDR_W], ex_rt[ADDR_W], ex_write_reg[ADDR_W], ex_funct[6]  output  registered ID/EX fields
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch[1 each], ex_alu_op[2]  output  registered ID/EX control
ex_illegal  output  1  registered; the instruction in EX has an undecoded opcode

Behaviour:
- Field split: opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0], imm=[15:0].
- ex_imm is imm sign-extended to 32 bits.
- Decode by opcode (all control bits not listed are 0):
  - 0x00 R-type: reg_write, reg_dst, alu_op=10.
  - 0x23 lw: alu_src, mem_read, mem_to_reg, reg_write, alu_op=00.
  - 0x2B sw: alu_src, mem_write, alu_op=00.
  - 0x04 beq: branch, alu_op=01.
  - 0x08 addi: alu_src, reg_write, alu_op=00.
  - Any other opcode: all control 0, illegal=1.
- Destination: write_reg = reg_dst ? rd : rt. If write_reg==0, reg_write is forced to 0.
- uses_rt = R-type, sw or beq.
- hazard = ex_valid & ex_mem_read & ex_write_reg!=0 & id_valid & (ex_write_reg==rs | (uses_rt & ex_write_reg==rt)).
- stall = hazard & ~flush.
- Next-state rule on each clock edge:
  - reset: every ex_* output becomes 0. Reset mid-stall clears the bubble and stall, since stall derives from ex_* state.
  - else if flush | hazard | ~id_valid: load a bubble. ex_valid=0, all control and ex_illegal=0. Data fields may hold any value and are don't-care, but the bench checks them as 0.
  - else: load the decoded instruction with ex_valid=1.
- Latency: 1 cycle from ID to ex_* outputs.
- A load-use stall lasts exactly 1 cycle, because the bubble clears the hazard.
- Simultaneous flush and hazard: flush wins; stall=0 and a bubble is loaded.
- Back-to-back loads to the same register: each dependent instruction gets exactly one bubble.
- There is no X-propagation from an invalid IF/ID: when id_valid=0, the decoded fields are ignored.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: operand A becomes wb_write_data when wb_reg_write & wb_write_addr!=0 & wb_write_addr==rs; otherwise rf_data_a. Operand B uses the same rule with rt. This gives same-cycle write-then-read correctness for the register file.
- Undefined: ex_data_a/ex_data_b take rf_data_a/rf_data_b unmodified; the upstream write-first arrangement is relied on.

Test Plan:
- reset=1 for 2 cycles, then instr=0x00221820 (add $3,$1,$2) with id_valid=1 and rf_data=5/7 -> after reset all ex_*=0. One cycle later: ex_valid=1, ex_data_a=5, ex_data_b=7, ex_write_reg=3, ex_reg_write=1, ex_alu_op=10.
- lw $2,-4($1) (0x8C22FFFC), then add using $2 -> ex_imm=0xFFFFFFFC and ex_mem_read=1. Next cycle stall=1 for exactly 1 cycle with ex_valid=0; the add issues the following cycle.
- The same load-use pair with flush=1 in the stall cycle -> stall=0, bubble loaded, no duplicate issue.
- WB_BYPASS_EN defined: wb_reg_write=1, wb_write_addr=1, wb_write_data=0xDEADBEEF, rs=1, rf_data_a=0 -> ex_data_a=0xDEADBEEF. Repeat with wb_write_addr=0 -> ex_data_a=0.
- Opcode 0x3F -> ex_illegal=1, ex_valid=1, all control 0. addi $0,$1,1 -> ex_reg_write=0.
- id_valid=0 with arbitrary instr -> ex_valid=0, all control 0, stall=0.
